reg_tx: RTL

Serial transmitter for the 8-bit register path. It accepts a parallel byte (normally the `Q` output of an 8-bit datapath register) with a ready/load handshake and sends it as an asynchronous serial frame: start bit, 8 data bits LSB-first, optional parity bit, stop bit. It is the sending end of the board's register readback link and sits between the register bank and the output pin.

---
 rtl/reg_tx.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/reg_tx.sv
// reg_tx -- serial transmitter for the 8-bit register readback link.
//
// Takes a parallel byte with a ready/load handshake and sends it as an
// asynchronous serial frame: start bit (0), 8 data bits LSB-first, an
// optional even-parity bit, and a stop bit (1). Every bit is held for
// CLKS_PER_BIT clock cycles.
//
// Optional feature macro: REG_TX_PARITY_EN
//   defined   -> 11-bit frame with an even-parity bit after the data bits
//   undefined -> 10-bit frame, no parity state or logic
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (1..65535)
//
// Ports:
//   clk    input   system clock, rising edge
//   rst    input   asynchronous active-low reset
//   D      input   byte to send, sampled only when a load is accepted
//   load   input   send request, accepted when ready=1 at a rising edge
//   ready  output  1 = idle and able to accept load
//   tx     output  serial line, idles high
//   done   output  one-cycle pulse in the first idle cycle after a stop bit
//
// All outputs come straight from flops; they are decoded from the next
// state so they change on the same edge as the state itself.

module reg_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] D,
  input  logic       load,
  output logic       ready,
  output logic       tx,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef REG_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [15:0] CYC_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] cyc_cnt_q, cyc_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        bit_end;

`ifdef REG_TX_PARITY_EN
  // Parity is taken from the byte at capture time, since the shift
  // register has been emptied by the time the parity bit goes out.
  logic        parity_q, parity_d;
`endif

  assign bit_end = (cyc_cnt_q == CYC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      cyc_cnt_q <= 16'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
`ifdef REG_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
`ifdef REG_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
`ifdef REG_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    // Every non-idle state holds its bit for CLKS_PER_BIT cycles; the
    // cycle counter restarts at each bit boundary.
    if (state_q != IDLE) begin
      cyc_cnt_d = bit_end ? 16'd0 : cyc_cnt_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d   = D;
          bit_cnt_d = 3'd0;
          cyc_cnt_d = 16'd0;
`ifdef REG_TX_PARITY_EN
          parity_d  = ^D;
`endif
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
`ifdef REG_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef REG_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state keeps tx/ready aligned with the
  // state register while still being driven by flops.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = 1'b0;
    case (state_d)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
      START: tx_d = 1'b0;
      DATA:  tx_d = shift_d[0];
`ifdef REG_TX_PARITY_EN
      PARITY: tx_d = parity_d;
`endif
      STOP:  tx_d = 1'b1;
      default: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule
